// File: rtl/sincos_nco.sv
// Quarter-wave LUT sine/cosine NCO: phase accumulator, 3-stage pipeline
// (phase/address/sign -> synchronous ROM read -> sign apply and output).
module sincos_nco #(
    parameter int unsigned PHASE_W    = 24,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned SIGNED_OUT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync_clr,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [PHASE_W-1:0] phase_ofs,
    output logic [OUT_W-1:0]   sine,
    output logic [OUT_W-1:0]   cos,
    output logic               out_valid,
    output logic               wrap
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned MAG_W = OUT_W - 1;
    localparam int unsigned TOP_W = ADDR_W + 2;
    localparam int unsigned SHIFT = PHASE_W - TOP_W;
    localparam longint PI_Q30 = 64'sd3373259426;
    localparam longint AMP = (64'sd1 <<< MAG_W) - 64'sd1;
    localparam logic [OUT_W-1:0] BASE = (SIGNED_OUT != 0) ? '0 : (OUT_W'(1) << (OUT_W - 1));

    // Elaboration-time round(AMP * sin(pi/2*(i+0.5)/DEPTH)) via Q30 Taylor series.
    function automatic longint mag_f(input longint i);
        longint x;
        longint term;
        longint sum;
        x    = (PI_Q30 * (2 * i + 1)) / (4 * longint'(DEPTH));
        term = x;
        sum  = x;
        for (longint k = 1; k <= 6; k++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / ((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return (AMP * sum + (64'sd1 <<< 29)) >>> 30;
    endfunction

    logic [MAG_W-1:0] lut [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_lut
        localparam longint MAG = mag_f(longint'(g));
        assign lut[g] = MAG_W'(MAG);
    end

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W:0]   acc_sum;
    logic [TOP_W-1:0]   ph_top;
    logic [1:0]         quad;
    logic [ADDR_W-1:0]  idx;

    logic               s1_valid;
    logic [ADDR_W-1:0]  s1_sin_addr;
    logic [ADDR_W-1:0]  s1_cos_addr;
    logic               s1_sin_neg;
    logic               s1_cos_neg;

    logic               s2_valid;
    logic [MAG_W-1:0]   s2_sin_mag;
    logic [MAG_W-1:0]   s2_cos_mag;
    logic               s2_sin_neg;
    logic               s2_cos_neg;

    logic [OUT_W-1:0]   sine_c;
    logic [OUT_W-1:0]   cos_c;

    // Accumulator carry and the quadrant/index of the pre-update phase.
    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, freq_word};
        ph_top  = TOP_W'((acc + phase_ofs) >> SHIFT);
        quad    = ph_top[TOP_W-1 -: 2];
        idx     = ph_top[ADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            wrap      <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            sine      <= BASE;
            cos       <= BASE;
        end else begin
            wrap     <= 1'b0;
            s1_valid <= en & ~sync_clr;
            if (sync_clr) begin
                acc <= '0;
            end else if (en) begin
                acc  <= acc_sum[PHASE_W-1:0];
                wrap <= acc_sum[PHASE_W];
            end
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                sine <= sine_c;
                cos  <= cos_c;
            end
        end
    end

    // Data path registers; qualified by the valid pipeline, so no reset needed.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_sin_addr <= quad[0] ? ~idx : idx;
            s1_cos_addr <= quad[0] ? idx : ~idx;
            s1_sin_neg  <= quad[1];
            s1_cos_neg  <= quad[1] ^ quad[0];
        end
        s2_sin_mag <= lut[s1_sin_addr];
        s2_cos_mag <= lut[s1_cos_addr];
        s2_sin_neg <= s1_sin_neg;
        s2_cos_neg <= s1_cos_neg;
    end

    always_comb begin
        sine_c = s2_sin_neg ? (BASE - OUT_W'(s2_sin_mag)) : (BASE + OUT_W'(s2_sin_mag));
        cos_c  = s2_cos_neg ? (BASE - OUT_W'(s2_cos_mag)) : (BASE + OUT_W'(s2_cos_mag));
    end

endmodule

// File: tb/tb_sincos_nco.sv
// Scoreboard bench for sincos_nco: offset-binary and two's-complement instances
// driven in parallel from directed vectors with hand-computed samples.
module tb_sincos_nco;
    localparam int unsigned PW = 24;
    localparam int unsigned OW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          sync_clr;
    logic [PW-1:0] freq_word;
    logic [PW-1:0] phase_ofs;
    logic [OW-1:0] sine_u, cos_u, sine_s, cos_s;
    logic          valid_u, valid_s, wrap_u, wrap_s;

    always #5 clk = ~clk;

    sincos_nco dut_u (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
        .freq_word(freq_word), .phase_ofs(phase_ofs),
        .sine(sine_u), .cos(cos_u), .out_valid(valid_u), .wrap(wrap_u)
    );

    sincos_nco #(.SIGNED_OUT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
        .freq_word(freq_word), .phase_ofs(phase_ofs),
        .sine(sine_s), .cos(cos_s), .out_valid(valid_s), .wrap(wrap_s)
    );

    typedef struct {
        int         due;
        logic [7:0] us, uc, ss, sc;
    } exp_t;

    typedef struct {
        logic        en, clr;
        logic [23:0] fw, ofs;
        logic [7:0]  us, uc, ss, sc;
        logic        wrap;
    } vec_t;

    exp_t sbq[$];
    int   wq[$];
    vec_t vecs[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;
    logic [7:0] last_us, last_uc, last_ss, last_sc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mkv(input logic e, input logic c, input logic [23:0] fw,
                                 input logic [23:0] ofs, input logic [7:0] us, input logic [7:0] uc,
                                 input logic [7:0] ss, input logic [7:0] sc, input logic w);
        vec_t v;
        v.en = e; v.clr = c; v.fw = fw; v.ofs = ofs;
        v.us = us; v.uc = uc; v.ss = ss; v.sc = sc; v.wrap = w;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        en = v.en; sync_clr = v.clr; freq_word = v.fw; phase_ofs = v.ofs;
        if (v.en && !v.clr) begin
            e.due = cyc + 3; e.us = v.us; e.uc = v.uc; e.ss = v.ss; e.sc = v.sc;
            sbq.push_back(e);
        end
        if (v.wrap) wq.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run_vecs();
        while (vecs.size() > 0) apply(vecs.pop_front());
    endtask

    // Monitor: pops the scoreboard on out_valid, otherwise checks held values.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic exp_w;
        if (mon_en && rst_n) begin
            exp_w = (wq.size() > 0) && (wq[0] == cyc);
            if (exp_w) void'(wq.pop_front());
            chk("wrap_u", 32'(wrap_u), 32'(exp_w));
            chk("wrap_s", 32'(wrap_s), 32'(exp_w));
            if (valid_u) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 32'(valid_u), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("latency", 32'(cyc), 32'(e.due));
                    chk("valid_s", 32'(valid_s), 32'd1);
                    chk("sine_u", 32'(sine_u), 32'(e.us));
                    chk("cos_u", 32'(cos_u), 32'(e.uc));
                    chk("sine_s", 32'(sine_s), 32'(e.ss));
                    chk("cos_s", 32'(cos_s), 32'(e.sc));
                    last_us = e.us; last_uc = e.uc; last_ss = e.ss; last_sc = e.sc;
                end
            end else begin
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    chk("sample_valid", 32'(valid_u), 32'd1);
                    void'(sbq.pop_front());
                end
                chk("valid_s_idle", 32'(valid_s), 32'd0);
                chk("hold_sine_u", 32'(sine_u), 32'(last_us));
                chk("hold_cos_u", 32'(cos_u), 32'(last_uc));
                chk("hold_sine_s", 32'(sine_s), 32'(last_ss));
                chk("hold_cos_s", 32'(cos_s), 32'(last_sc));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_sine_u"}, 32'(sine_u), 32'h80);
        chk({tag, "_cos_u"}, 32'(cos_u), 32'h80);
        chk({tag, "_sine_s"}, 32'(sine_s), 32'h00);
        chk({tag, "_cos_s"}, 32'(cos_s), 32'h00);
        chk({tag, "_valid"}, 32'(valid_u | valid_s), 32'd0);
        chk({tag, "_wrap"}, 32'(wrap_u | wrap_s), 32'd0);
        last_us = 8'h80; last_uc = 8'h80; last_ss = 8'h00; last_sc = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; freq_word = '0; phase_ofs = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("por");
        mon_en = 1'b1;

        // Single sample at phase 0, then idle to observe hold.
        vecs.push_back(mkv(1, 0, 24'h000000, 24'h000000, 8'h80, 8'hFF, 8'h00, 8'h7F, 0));
        run_vecs();
        idle(3);

        // Quarter-turn steps, back to back, carry on the fourth.
        vecs.push_back(mkv(1, 0, 24'h400000, 24'h000000, 8'h80, 8'hFF, 8'h00, 8'h7F, 0));
        vecs.push_back(mkv(1, 0, 24'h400000, 24'h000000, 8'hFF, 8'h80, 8'h7F, 8'h00, 0));
        vecs.push_back(mkv(1, 0, 24'h400000, 24'h000000, 8'h80, 8'h01, 8'h00, 8'h81, 0));
        vecs.push_back(mkv(1, 0, 24'h400000, 24'h000000, 8'h01, 8'h80, 8'h81, 8'h00, 1));
        // Offset-only phases with acc back at 0, including interior LUT entries.
        vecs.push_back(mkv(1, 0, 24'h000000, 24'h200000, 8'hDA, 8'hDA, 8'h5A, 8'h5A, 0));
        vecs.push_back(mkv(1, 0, 24'h000000, 24'h600000, 8'hDA, 8'h26, 8'h5A, 8'hA6, 0));
        vecs.push_back(mkv(1, 0, 24'h000000, 24'h004000, 8'h81, 8'hFF, 8'h01, 8'h7F, 0));
        vecs.push_back(mkv(1, 0, 24'h000000, 24'h800000, 8'h80, 8'h01, 8'h00, 8'h81, 0));
        vecs.push_back(mkv(1, 0, 24'h000000, 24'hC00000, 8'h01, 8'h80, 8'h81, 8'h00, 0));
        // Move acc to 0xC00000, then clear with a carrying en: no sample, no wrap.
        vecs.push_back(mkv(1, 0, 24'hC00000, 24'h000000, 8'h80, 8'hFF, 8'h00, 8'h7F, 0));
        vecs.push_back(mkv(1, 1, 24'h400000, 24'h000000, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mkv(1, 0, 24'h000000, 24'h000000, 8'h80, 8'hFF, 8'h00, 8'h7F, 0));
        run_vecs();
        idle(4);

        // Reset with samples in flight.
        vecs.push_back(mkv(1, 0, 24'h400000, 24'h000000, 8'h80, 8'hFF, 8'h00, 8'h7F, 0));
        vecs.push_back(mkv(1, 0, 24'h400000, 24'h000000, 8'hFF, 8'h80, 8'h7F, 8'h00, 0));
        vecs.push_back(mkv(1, 0, 24'h400000, 24'h000000, 8'h80, 8'h01, 8'h00, 8'h81, 0));
        run_vecs();
        @(posedge clk);
        #1 en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_reset_state("flight_rst");
        sbq.delete();
        wq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(6);

        vecs.push_back(mkv(1, 0, 24'h000000, 24'h000000, 8'h80, 8'hFF, 8'h00, 8'h7F, 0));
        run_vecs();
        idle(5);

        @(negedge clk);
        chk("sbq_drained", 32'(sbq.size()), 32'd0);
        chk("wrap_drained", 32'(wq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
